// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and the signature fold used by the truth-table sweep engine.
package truth_table_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE_ST = 2'd2
   } sweep_state_t;

   // Widest signature the shared fold supports; callers truncate to their own width.
   localparam int SIG_MAX_W = 64;

   // One signature step: rotate left by one within `width` bits, then xor in the response.
   // Bits at and above `width` are don't-care and are dropped by the caller.
   function automatic logic [SIG_MAX_W-1:0] rotl1_xor(
      input logic [SIG_MAX_W-1:0] sig,
      input logic [SIG_MAX_W-1:0] resp,
      input int                   width
   );
      logic [SIG_MAX_W-1:0] rot;
      rot = (sig << 1) | (sig >> (width - 1));
      return rot ^ resp;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_tt_ram.sv
// Register-file truth table: synchronous write, registered read, cleared on reset.
// A same-cycle write and read of one address returns the old entry.
module tt_ram #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= wr_data;
         end
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable N_IN-in / N_OUT-out Boolean function with an exhaustive sweep engine
// that walks every input vector, holds it DWELL cycles and folds the responses into SIG.
module truth_table_sweeper #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2,
   parameter int DWELL = 100,
   parameter int SIG_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_IN-1:0]  IN,
   input  logic             WR_EN,
   input  logic [N_IN-1:0]  WR_ADDR,
   input  logic [N_OUT-1:0] WR_DATA,
   input  logic             START,
   input  logic             ABORT,
   output logic [N_IN-1:0]  VEC,
   output logic [N_OUT-1:0] F,
   output logic             BUSY,
   output logic             DONE,
   output logic [SIG_W-1:0] SIG
);

   import truth_table_sweeper_pkg::*;

   localparam int             DW_W       = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [N_IN-1:0] VEC_LAST   = '1;

   sweep_state_t     state;
   sweep_state_t     next_state;
   logic [N_IN-1:0]  vec_cnt;
   logic [DW_W-1:0]  dwell_cnt;
   logic [N_IN-1:0]  rd_addr;
   logic [SIG_W-1:0] sig_next;
   logic             start_sweep;
   logic             sample_now;

   assign rd_addr  = (state == RUN) ? vec_cnt : IN;
   assign sig_next = SIG_W'(rotl1_xor(SIG_MAX_W'(SIG), SIG_MAX_W'(F), SIG_W));

   tt_ram #(
      .ADDR_W (N_IN),
      .DATA_W (N_OUT)
   ) u_tt_ram (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (WR_EN),
      .wr_addr (WR_ADDR),
      .wr_data (WR_DATA),
      .rd_addr (rd_addr),
      .rd_data (F)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ABORT beats START in IDLE; in RUN it beats the dwell-end sample, so SIG keeps its partial value.
   always_comb begin
      next_state  = state;
      start_sweep = 1'b0;
      sample_now  = 1'b0;
      BUSY        = 1'b0;
      DONE        = 1'b0;
      unique case (state)
         IDLE: begin
            if (START && !ABORT) begin
               next_state  = RUN;
               start_sweep = 1'b1;
            end
         end
         RUN: begin
            BUSY = 1'b1;
            if (ABORT) begin
               next_state = IDLE;
            end else if (dwell_cnt == DWELL_LAST) begin
               sample_now = 1'b1;
               if (vec_cnt == VEC_LAST) begin
                  next_state = DONE_ST;
               end
            end
         end
         DONE_ST: begin
            DONE       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // VEC tracks the address whose lookup lands in F on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vec_cnt   <= '0;
         dwell_cnt <= '0;
         SIG       <= '0;
         VEC       <= '0;
      end else begin
         VEC <= rd_addr;
         if (start_sweep) begin
            vec_cnt   <= '0;
            dwell_cnt <= '0;
            SIG       <= '0;
         end else if (state == RUN) begin
            if (ABORT) begin
               dwell_cnt <= '0;
            end else if (sample_now) begin
               dwell_cnt <= '0;
               SIG       <= sig_next;
               if (vec_cnt != VEC_LAST) begin
                  vec_cnt <= vec_cnt + 1'b1;
               end
            end else begin
               dwell_cnt <= dwell_cnt + 1'b1;
            end
         end
      end
   end

endmodule
